// File: rtl/csi2_pkt_to_video.sv
// Converts a decoded CSI-2 packet stream into a video stream for one VC/DT pair.
// Frame and line bookkeeping comes from FS/FE short packets. Line payload is trimmed to WC bytes.
module csi2_pkt_to_video #(
    parameter logic [1:0] VIRT_CHAN = 2'd0,
    parameter logic [5:0] DATA_TYPE = 6'h2B
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [31:0] pkt_tdata_i,
    input  logic        pkt_tvalid_i,
    input  logic [3:0]  pkt_tstrb_i,
    input  logic        pkt_tlast_i,
    output logic [31:0] video_tdata_o,
    output logic        video_tvalid_o,
    output logic [3:0]  video_tstrb_o,
    output logic        video_tuser_o,
    output logic        video_tlast_o,
    output logic [15:0] frame_num_o,
    output logic [15:0] line_cnt_o,
    output logic        frame_active_o,
    output logic        frame_end_o,
    output logic        trunc_err_o,
    output logic        orphan_line_o
);
    typedef enum logic [1:0] {HEADER, PAYLOAD, DROP, DISCARD} state_t;

    state_t      state_reg, state_next;
    logic [31:0] video_tdata_reg, video_tdata_next;
    logic        video_tvalid_reg, video_tvalid_next;
    logic [3:0]  video_tstrb_reg, video_tstrb_next;
    logic        video_tuser_reg, video_tuser_next;
    logic        video_tlast_reg, video_tlast_next;
    logic [15:0] frame_num_reg, frame_num_next;
    logic [15:0] line_cnt_reg, line_cnt_next;
    logic        frame_active_reg, frame_active_next;
    logic        frame_end_reg, frame_end_next;
    logic        trunc_err_reg, trunc_err_next;
    logic        orphan_line_reg, orphan_line_next;
    logic        sof_reg, sof_next;
    logic        first_reg, first_next;
    logic [15:0] remaining_reg, remaining_next;

    logic [1:0]  hdr_vc;
    logic [5:0]  hdr_dt;
    logic [15:0] hdr_wc;
    logic        vc_match, is_long, long_match, rem_gt4;

    assign hdr_vc     = pkt_tdata_i[7:6];
    assign hdr_dt     = pkt_tdata_i[5:0];
    assign hdr_wc     = pkt_tdata_i[23:8];
    assign vc_match   = (hdr_vc == VIRT_CHAN);
    assign is_long    = (hdr_dt >= 6'h10);
    assign long_match = vc_match && (hdr_dt == DATA_TYPE);
    assign rem_gt4    = (remaining_reg > 16'd4);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg <= HEADER;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (pkt_tvalid_i) begin
            case (state_reg)
                HEADER: begin
                    // A header that also carries tlast is a one-word packet: nothing to consume.
                    if (is_long && !pkt_tlast_i) begin
                        if (!long_match)
                            state_next = DISCARD;
                        else if (hdr_wc != 16'd0)
                            state_next = PAYLOAD;
                        else
                            state_next = DROP;
                    end
                end
                PAYLOAD: begin
                    if (pkt_tlast_i)
                        state_next = HEADER;
                    else if (!rem_gt4)
                        state_next = DROP;
                end
                default: begin
                    if (pkt_tlast_i)
                        state_next = HEADER;
                end
            endcase
        end
    end

    always_comb begin
        video_tdata_next  = pkt_tdata_i;
        video_tvalid_next = 1'b0;
        video_tstrb_next  = 4'b0000;
        video_tuser_next  = 1'b0;
        video_tlast_next  = 1'b0;
        frame_num_next    = frame_num_reg;
        line_cnt_next     = line_cnt_reg;
        frame_active_next = frame_active_reg;
        frame_end_next    = 1'b0;
        trunc_err_next    = 1'b0;
        orphan_line_next  = 1'b0;
        sof_next          = sof_reg;
        first_next        = first_reg;
        remaining_next    = remaining_reg;
        if (pkt_tvalid_i) begin
            case (state_reg)
                HEADER: begin
                    if (vc_match && hdr_dt == 6'h00) begin
                        frame_num_next    = hdr_wc;
                        frame_active_next = 1'b1;
                        line_cnt_next     = 16'd0;
                        sof_next          = 1'b1;
                    end else if (vc_match && hdr_dt == 6'h01) begin
                        frame_active_next = 1'b0;
                        frame_end_next    = 1'b1;
                        sof_next          = 1'b0;
                    end else if (is_long && long_match) begin
                        if (pkt_tlast_i) begin
                            trunc_err_next = 1'b1;
                        end else if (hdr_wc != 16'd0) begin
                            remaining_next = hdr_wc;
                            line_cnt_next  = line_cnt_reg + 16'd1;
                            first_next     = 1'b1;
                        end
                    end
                end
                PAYLOAD: begin
                    video_tvalid_next = 1'b1;
                    first_next        = 1'b0;
                    // Only the first word of a line can carry SOF or flag an orphan line.
                    if (first_reg) begin
                        video_tuser_next = sof_reg && frame_active_reg;
                        orphan_line_next = !frame_active_reg;
                        sof_next         = 1'b0;
                    end
                    if (rem_gt4 && pkt_tlast_i) begin
                        video_tstrb_next = pkt_tstrb_i;
                        video_tlast_next = 1'b1;
                        trunc_err_next   = 1'b1;
                        remaining_next   = 16'd0;
                    end else if (rem_gt4) begin
                        video_tstrb_next = 4'b1111;
                        remaining_next   = remaining_reg - 16'd4;
                    end else begin
                        case (remaining_reg[2:0])
                            3'd1:    video_tstrb_next = 4'b0001;
                            3'd2:    video_tstrb_next = 4'b0011;
                            3'd3:    video_tstrb_next = 4'b0111;
                            default: video_tstrb_next = 4'b1111;
                        endcase
                        video_tlast_next = 1'b1;
                        remaining_next   = 16'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            video_tdata_reg  <= 32'd0;
            video_tvalid_reg <= 1'b0;
            video_tstrb_reg  <= 4'd0;
            video_tuser_reg  <= 1'b0;
            video_tlast_reg  <= 1'b0;
            frame_num_reg    <= 16'd0;
            line_cnt_reg     <= 16'd0;
            frame_active_reg <= 1'b0;
            frame_end_reg    <= 1'b0;
            trunc_err_reg    <= 1'b0;
            orphan_line_reg  <= 1'b0;
            sof_reg          <= 1'b0;
            first_reg        <= 1'b0;
            remaining_reg    <= 16'd0;
        end else begin
            video_tdata_reg  <= video_tdata_next;
            video_tvalid_reg <= video_tvalid_next;
            video_tstrb_reg  <= video_tstrb_next;
            video_tuser_reg  <= video_tuser_next;
            video_tlast_reg  <= video_tlast_next;
            frame_num_reg    <= frame_num_next;
            line_cnt_reg     <= line_cnt_next;
            frame_active_reg <= frame_active_next;
            frame_end_reg    <= frame_end_next;
            trunc_err_reg    <= trunc_err_next;
            orphan_line_reg  <= orphan_line_next;
            sof_reg          <= sof_next;
            first_reg        <= first_next;
            remaining_reg    <= remaining_next;
        end
    end

    assign video_tdata_o  = video_tdata_reg;
    assign video_tvalid_o = video_tvalid_reg;
    assign video_tstrb_o  = video_tstrb_reg;
    assign video_tuser_o  = video_tuser_reg;
    assign video_tlast_o  = video_tlast_reg;
    assign frame_num_o    = frame_num_reg;
    assign line_cnt_o     = line_cnt_reg;
    assign frame_active_o = frame_active_reg;
    assign frame_end_o    = frame_end_reg;
    assign trunc_err_o    = trunc_err_reg;
    assign orphan_line_o  = orphan_line_reg;
endmodule

// File: doc/csi2_pkt_to_video.md
CSI2_PKT_TO_VIDEO -- requirements
Module: csi2_pkt_to_video

Interface
REQ-001 SHALL have parameter VIRT_CHAN, default 2'd0, the virtual channel accepted.
REQ-002 SHALL have parameter DATA_TYPE, default 6'h2B (RAW10), the long-packet data type forwarded.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock (upstream byte-clock domain).
REQ-004 SHALL have port rst_n_i, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 SHALL have ports pkt_tdata_i (in, 32), pkt_tvalid_i (in, 1), pkt_tstrb_i (in, 4) and pkt_tlast_i (in, 1): the decoded CSI-2 packet stream, with no backpressure.
REQ-006 SHALL have ports video_tdata_o (out, 32), video_tvalid_o (out, 1), video_tstrb_o (out, 4), video_tuser_o (out, 1, start of frame) and video_tlast_o (out, 1, end of line).
REQ-007 SHALL have ports frame_num_o (out, 16), line_cnt_o (out, 16) and frame_active_o (out, 1).
REQ-008 SHALL have ports frame_end_o, trunc_err_o and orphan_line_o (out, 1 each): single-cycle pulses.

Function
REQ-009 SHALL treat each input word as follows: the first valid word after reset or after a word with pkt_tlast_i=1 is a header, with DI=tdata[7:0] (VC=DI[7:6], DT=DI[5:0]), WC=tdata[23:8] and ECC=tdata[31:24], ECC ignored.
REQ-010 SHALL implement an FSM with states HEADER, PAYLOAD, DROP and DISCARD; reset state is HEADER.
REQ-011 SHALL, in HEADER: DT=0x00 and VC match -> frame_num_o<=WC, frame_active_o<=1, line_cnt_o<=0, arm SOF flag; stay HEADER.
REQ-012 SHALL, in HEADER: DT=0x01 and VC match -> frame_active_o<=0, pulse frame_end_o; stay HEADER.
REQ-013 SHALL, in HEADER: other DT<0x10 -> ignored; stay HEADER.
REQ-014 SHALL, in HEADER: DT>=0x10 with VC/DT mismatch -> DISCARD; a header word carrying pkt_tlast_i=1 stays HEADER.
REQ-015 SHALL, in HEADER: long-packet match with WC>0 -> PAYLOAD with remaining<=WC and line_cnt_o incremented; WC=0 -> DROP.
REQ-016 SHALL, in HEADER: a long-packet match with pkt_tlast_i=1 on the header -> pulse trunc_err_o, stay HEADER, no output.
REQ-017 SHALL, in PAYLOAD, per valid word: forward tdata; tstrb=4'b1111 if remaining>4, else the low `remaining` bytes set (1->0001, 2->0011, 3->0111, 4->1111); remaining<=remaining-4 (saturating at 0).
REQ-018 SHALL, in PAYLOAD, assert video_tlast_o when remaining<=4; next state HEADER if pkt_tlast_i=1, else DROP.
REQ-019 SHALL, in PAYLOAD, handle pkt_tlast_i=1 with remaining>4 as follows: forward the word with tstrb=pkt_tstrb_i, video_tlast_o=1 and trunc_err_o pulsed, then go to HEADER.
REQ-020 SHALL, in PAYLOAD, set video_tuser_o=1 on the first output word after an armed SOF and clear the SOF flag on that word.
REQ-021 SHALL, when a payload starts with frame_active_o=0, still forward it, pulse orphan_line_o on its first word and leave video_tuser_o at 0.
REQ-022 SHALL, in DROP (CRC bytes) and DISCARD, consume words with no output and go to HEADER on pkt_tlast_i=1.
REQ-023 SHALL ignore words with pkt_tvalid_i=0 in all states; pkt_tstrb_i is not used outside REQ-019.
REQ-024 SHALL register all video_* outputs: latency is exactly 1 clk_i from the input word; video_tvalid_o=0 on cycles with no forwarded word, and the other video_* outputs are then don't-care.
REQ-025 SHALL make line_cnt_o and frame_num_o wrap modulo 2^16.
REQ-026 SHALL, when an FS arrives while frame_active_o=1, restart the frame (line_cnt_o=0, SOF re-armed) without pulsing frame_end_o.

Reset
REQ-027 SHALL, while rst_n_i=0, force all outputs, counters and flags to 0, the FSM to HEADER and the SOF flag cleared, independent of clk_i.
REQ-028 SHALL, after rst_n_i deasserts (including mid-packet), treat the first valid input word as a header.

Verification
REQ-029 SHALL verify: FS VC0 WC=5 (tdata 0x00000500), then long DT 0x2B WC=10 as 3 payload words, the third with tlast -> 3 output words with tstrb 1111/1111/0011, tuser on word 1, tlast on word 3, frame_num_o=5, line_cnt_o=1, FSM back to HEADER with no DROP.
REQ-030 SHALL verify: WC=8 with a separate CRC word carrying tlast -> 2 output words, tlast on word 2, the CRC word not forwarded.
REQ-031 SHALL verify: a long packet with VC=1 or DT=0x2A -> no video_tvalid_o, line_cnt_o unchanged.
REQ-032 SHALL verify: WC=16 but pkt_tlast_i on payload word 2 -> word 2 output with tlast=1 and trunc_err_o=1 for one cycle; the next header is decoded correctly.
REQ-033 SHALL verify: FE (DT 0x01) -> frame_end_o for one cycle and frame_active_o=0; a following line -> orphan_line_o=1 and tuser=0.
REQ-034 SHALL verify: rst_n_i pulsed low mid-PAYLOAD -> outputs 0 immediately; the next word is decoded as a header.
